// File: rtl/rv_decode_stage_pkg.sv
// Shared ALU operation codes, RV32I opcode/funct7 constants and decode helpers
// for the yarv decode stage.
package rv_decode_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLT  = 4'd1,
    ALU_SLTU = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SUB  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Operation selected by funct3 alone; SUB/SRA are picked by funct7.
  function automatic alu_op_e base_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  // The alternate funct7 is allowed for SUB (register form only) and SRA.
  function automatic logic funct7_ok(input logic [2:0] funct3, input logic [6:0] funct7,
                                     input logic reg_form);
    logic alt_allowed;
    alt_allowed = (funct3 == 3'b101) || (reg_form && funct3 == 3'b000);
    funct7_ok = (funct7 == F7_ZERO) || (alt_allowed && funct7 == F7_ALT);
  endfunction

endpackage

// File: rtl/rv_decode_stage_if.sv
// Decode-to-execute channel: valid/ready handshake plus the decoded ALU entry.
interface rv_decode_stage_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 4
);
  logic                   valid;
  logic                   ready;
  logic [INSTR_WIDTH-1:0] operation;
  logic [DATA_WIDTH-1:0]  op_a;
  logic [DATA_WIDTH-1:0]  op_b;
  logic [4:0]             rd_addr;
  logic                   rd_we;
  logic                   illegal;

  modport master (
    output valid, operation, op_a, op_b, rd_addr, rd_we, illegal,
    input  ready
  );

  modport slave (
    input  valid, operation, op_a, op_b, rd_addr, rd_we, illegal,
    output ready
  );
endinterface

// File: rtl/rv_instr_decode.sv
// Combinational RV32I decoder for the OP, OP-IMM, LUI and AUIPC classes;
// everything else becomes an illegal entry with zeroed operands.
module rv_instr_decode
  import rv_decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output alu_op_e               operation,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [4:0]            rd_addr,
  output logic                  rd_we,
  output logic                  illegal
);

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [4:0]            rd;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_u;
  logic                  legal;
  alu_op_e               op_sel;
  logic [DATA_WIDTH-1:0] raw_a;
  logic [DATA_WIDTH-1:0] raw_b;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  assign imm_i  = DATA_WIDTH'($signed(instr[31:20]));
  assign imm_u  = DATA_WIDTH'($signed({instr[31:12], 12'b0}));

  always_comb begin
    legal  = 1'b0;
    op_sel = base_op(funct3);
    raw_a  = '0;
    raw_b  = '0;
    case (opcode)
      OPC_OP: begin
        legal = funct7_ok(funct3, funct7, 1'b1);
        raw_a = rs1_data;
        raw_b = rs2_data;
        if (funct7 == F7_ALT && funct3 == 3'b000) op_sel = ALU_SUB;
        if (funct7 == F7_ALT && funct3 == 3'b101) op_sel = ALU_SRA;
      end
      OPC_OP_IMM: begin
        // Only the shifts treat instr[31:25] as funct7; elsewhere it is immediate.
        legal = (funct3 == 3'b001 || funct3 == 3'b101) ? funct7_ok(funct3, funct7, 1'b0) : 1'b1;
        raw_a = rs1_data;
        raw_b = imm_i;
        if (funct7 == F7_ALT && funct3 == 3'b101) op_sel = ALU_SRA;
      end
      OPC_LUI: begin
        legal  = 1'b1;
        op_sel = ALU_ADD;
        raw_b  = imm_u;
      end
      OPC_AUIPC: begin
        legal  = 1'b1;
        op_sel = ALU_ADD;
        raw_a  = pc;
        raw_b  = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  assign operation = legal ? op_sel : ALU_ADD;
  assign op_a      = legal ? raw_a : '0;
  assign op_b      = legal ? raw_b : '0;
  assign rd_addr   = legal ? rd : 5'd0;
  assign rd_we     = legal && (rd != 5'd0);
  assign illegal   = !legal;

endmodule

// File: rtl/rv_decode_stage.sv
// Decode stage top: register-file address fan-out, decoder, and a two-entry
// skid buffer so both the fetch and execute handshakes are registered.
module rv_decode_stage
  import rv_decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [4:0]            rf_rs1_addr,
  output logic [4:0]            rf_rs2_addr,
  input  logic [DATA_WIDTH-1:0] rf_rs1_data,
  input  logic [DATA_WIDTH-1:0] rf_rs2_data,
  rv_decode_stage_if.master     ex
);

  localparam int EW = INSTR_WIDTH + 2 * DATA_WIDTH + 7;

  alu_op_e               dec_op;
  logic [DATA_WIDTH-1:0] dec_a;
  logic [DATA_WIDTH-1:0] dec_b;
  logic [4:0]            dec_rd;
  logic                  dec_we;
  logic                  dec_ill;
  logic [EW-1:0]         dec_entry;

  logic [EW-1:0] main_reg, main_next;
  logic [EW-1:0] skid_reg, skid_next;
  logic          main_valid_reg, main_valid_next;
  logic          skid_valid_reg, skid_valid_next;
  logic          ready_reg, ready_next;
  logic          accept;
  logic          advance;
  logic          main_free;

  assign rf_rs1_addr = instr[19:15];
  assign rf_rs2_addr = instr[24:20];

  rv_instr_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rf_rs1_data),
    .rs2_data  (rf_rs2_data),
    .operation (dec_op),
    .op_a      (dec_a),
    .op_b      (dec_b),
    .rd_addr   (dec_rd),
    .rd_we     (dec_we),
    .illegal   (dec_ill)
  );

  assign dec_entry = {INSTR_WIDTH'(dec_op), dec_a, dec_b, dec_rd, dec_we, dec_ill};

  assign accept    = instr_valid && ready_reg;
  assign advance   = main_valid_reg && ex.ready;
  assign main_free = advance || !main_valid_reg;

  // ready_reg high guarantees the skid is empty, so accept never meets a full skid.
  always_comb begin
    main_next       = main_reg;
    skid_next       = skid_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    if (flush) begin
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (main_free) begin
      if (skid_valid_reg) begin
        main_next       = skid_reg;
        main_valid_next = 1'b1;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        main_next       = dec_entry;
        main_valid_next = 1'b1;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (accept) begin
      skid_next       = dec_entry;
      skid_valid_next = 1'b1;
    end
    ready_next = !skid_valid_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b1;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      ready_reg      <= ready_next;
    end
  end

  assign instr_ready = ready_reg;
  assign ex.valid    = main_valid_reg;
  assign {ex.operation, ex.op_a, ex.op_b, ex.rd_addr, ex.rd_we, ex.illegal} = main_reg;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed and randomized checks of rv_decode_stage against a queue-based
// reference model of the decode rules and two-entry buffering.
module tb_rv_decode_stage;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1_data;
  logic [31:0] rf_rs2_data;
  logic [31:0] regs [32];

  int   n_checks;
  int   n_fail;
  exp_t q[$];
  logic m_ready;

  rv_decode_stage_if #(.DATA_WIDTH(32), .INSTR_WIDTH(4)) ex_if ();

  rv_decode_stage #(.DATA_WIDTH(32), .INSTR_WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc          (pc),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .ex          (ex_if)
  );

  assign rf_rs1_data = regs[rf_rs1_addr];
  assign rf_rs2_data = regs[rf_rs2_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  function automatic int base_code(input logic [2:0] f3);
    case (f3)
      3'd0: return 0;
      3'd1: return 6;
      3'd2: return 1;
      3'd3: return 2;
      3'd4: return 5;
      3'd5: return 7;
      3'd6: return 4;
      default: return 3;
    endcase
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] p);
    exp_t        e;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ok;
    int          code;
    opc  = ins[6:0];
    f3   = ins[14:12];
    f7   = ins[31:25];
    e    = '0;
    ok   = 1'b0;
    code = 0;
    if (opc == 7'h33 || opc == 7'h13) begin
      e.a  = regs[ins[19:15]];
      e.b  = (opc == 7'h33) ? regs[ins[24:20]] : {{20{ins[31]}}, ins[31:20]};
      code = base_code(f3);
      if (opc == 7'h13 && f3 != 3'd1 && f3 != 3'd5) ok = 1'b1;
      else if (f7 == 7'h00) ok = 1'b1;
      else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; code = 9; end
      else if (f7 == 7'h20 && f3 == 3'd0 && opc == 7'h33) begin ok = 1'b1; code = 8; end
    end else if (opc == 7'h37) begin
      ok  = 1'b1;
      e.b = {ins[31:12], 12'h000};
    end else if (opc == 7'h17) begin
      ok  = 1'b1;
      e.a = p;
      e.b = {ins[31:12], 12'h000};
    end
    if (ok) begin
      e.op = 4'(code);
      e.rd = ins[11:7];
      e.we = (ins[11:7] != 5'd0);
    end else begin
      e     = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // One clock: model update from pre-edge inputs, then compare after the edge.
  task automatic tick();
    logic acc;
    logic adv;
    exp_t e;
    #1;
    chk("rs1_addr", 32'(rf_rs1_addr), 32'(instr[19:15]));
    chk("rs2_addr", 32'(rf_rs2_addr), 32'(instr[24:20]));
    acc = instr_valid && m_ready;
    adv = (q.size() > 0) && ex_if.ready;
    e   = ref_decode(instr, pc);
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
    end else begin
      if (adv) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    m_ready = (q.size() < 2);
    #1;
    chk("ex_valid", 32'(ex_if.valid), 32'(q.size() > 0));
    chk("instr_ready", 32'(instr_ready), 32'(m_ready));
    if (q.size() > 0) begin
      chk("operation", 32'(ex_if.operation), 32'(q[0].op));
      chk("op_a", ex_if.op_a, q[0].a);
      chk("op_b", ex_if.op_b, q[0].b);
      chk("rd_addr", 32'(ex_if.rd_addr), 32'(q[0].rd));
      chk("rd_we", 32'(ex_if.rd_we), 32'(q[0].we));
      chk("illegal", 32'(ex_if.illegal), 32'(q[0].ill));
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                       input logic rdy, input logic fl);
    instr_valid = v;
    instr       = ins;
    pc          = p;
    ex_if.ready = rdy;
    flush       = fl;
    tick();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  opc;
    logic [6:0]  f7;
    int          sel;
    r   = $urandom;
    sel = $urandom_range(0, 7);
    case (sel)
      0, 1:    opc = 7'h33;
      2, 3:    opc = 7'h13;
      4:       opc = 7'h37;
      5:       opc = 7'h17;
      6:       opc = 7'h03;
      default: opc = r[6:0];
    endcase
    sel = $urandom_range(0, 9);
    f7  = (sel < 5) ? 7'h00 : (sel < 8) ? 7'h20 : r[31:25];
    r[6:0] = opc;
    if (opc == 7'h33 || opc == 7'h13) r[31:25] = f7;
    return r;
  endfunction

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    m_ready     = 1'b1;
    rst         = 1'b1;
    flush       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'h0;
    pc          = 32'h0;
    ex_if.ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'h0;
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    regs[6] = 32'h8000_0000;

    tick();
    tick();
    rst = 1'b0;
    chk("reset_valid", 32'(ex_if.valid), 32'd0);
    chk("reset_ready", 32'(instr_ready), 32'd1);
    chk("reset_op", 32'(ex_if.operation), 32'd0);
    chk("reset_a", ex_if.op_a, 32'd0);
    chk("reset_b", ex_if.op_b, 32'd0);
    chk("reset_rd", 32'(ex_if.rd_addr), 32'd0);
    chk("reset_we", 32'(ex_if.rd_we), 32'd0);
    chk("reset_ill", 32'(ex_if.illegal), 32'd0);

    drive(1'b1, 32'h002081B3, 32'h0, 1'b1, 1'b0);
    chk("add_op", 32'(ex_if.operation), 32'd0);
    chk("add_a", ex_if.op_a, 32'd5);
    chk("add_b", ex_if.op_b, 32'd7);
    chk("add_rd", 32'(ex_if.rd_addr), 32'd3);
    chk("add_we", 32'(ex_if.rd_we), 32'd1);

    drive(1'b1, 32'h40435293, 32'h0, 1'b1, 1'b0);
    chk("srai_op", 32'(ex_if.operation), 32'd9);
    chk("srai_a", ex_if.op_a, 32'h8000_0000);
    chk("srai_shamt", 32'(ex_if.op_b[4:0]), 32'd4);
    chk("srai_rd", 32'(ex_if.rd_addr), 32'd5);

    drive(1'b1, 32'h40431293, 32'h0, 1'b1, 1'b0);
    chk("slli30_ill", 32'(ex_if.illegal), 32'd1);
    chk("slli30_we", 32'(ex_if.rd_we), 32'd0);

    drive(1'b1, 32'h12345097, 32'h100, 1'b1, 1'b0);
    chk("auipc_op", 32'(ex_if.operation), 32'd0);
    chk("auipc_a", ex_if.op_a, 32'h100);
    chk("auipc_b", ex_if.op_b, 32'h1234_5000);

    drive(1'b1, 32'hABCDE037, 32'h0, 1'b1, 1'b0);
    chk("lui_x0_we", 32'(ex_if.rd_we), 32'd0);
    chk("lui_x0_ill", 32'(ex_if.illegal), 32'd0);
    chk("lui_b", ex_if.op_b, 32'hABCD_E000);

    drive(1'b1, 32'h0000_0000, 32'h40, 1'b1, 1'b0);
    chk("zero_ill", 32'(ex_if.illegal), 32'd1);
    chk("zero_b", ex_if.op_b, 32'd0);
    drive(1'b1, 32'h00012083, 32'h44, 1'b1, 1'b0);
    chk("load_ill", 32'(ex_if.illegal), 32'd1);
    chk("load_op", 32'(ex_if.operation), 32'd0);
    chk("load_a", ex_if.op_a, 32'd0);
    chk("load_we", 32'(ex_if.rd_we), 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Back-to-back with execute stalled: two buffered, the third held off.
    drive(1'b1, 32'h00100093, 32'h0, 1'b0, 1'b0);
    chk("bb1_ready", 32'(instr_ready), 32'd1);
    drive(1'b1, 32'h00200113, 32'h4, 1'b0, 1'b0);
    chk("bb2_ready", 32'(instr_ready), 32'd0);
    chk("bb2_rd", 32'(ex_if.rd_addr), 32'd1);
    drive(1'b1, 32'h00300193, 32'h8, 1'b0, 1'b0);
    chk("bb3_hold_rd", 32'(ex_if.rd_addr), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bb_rel_ready", 32'(instr_ready), 32'd1);
    chk("bb_rel_rd", 32'(ex_if.rd_addr), 32'd2);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("bb_drained", 32'(ex_if.valid), 32'd0);

    // Flush with the skid full and a new instruction on the input.
    drive(1'b1, 32'h00100093, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h00200113, 32'h4, 1'b0, 1'b0);
    drive(1'b1, 32'h00300193, 32'h8, 1'b0, 1'b1);
    chk("flush_valid", 32'(ex_if.valid), 32'd0);
    chk("flush_ready", 32'(instr_ready), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("flush_gone", 32'(ex_if.valid), 32'd0);

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) < 7, rand_instr(), $urandom,
            $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
